trig_issuer: RTL

- Source end of the trig/din/crfm capture interface. Drives a byte on din, pulses trig, and waits for the capture side to assert crfm.
- Bytes are queued from an upstream valid/ready port into a small FIFO and issued strictly in order.
- Unacknowledged issues are retried a bounded number of times, then dropped with an error pulse.
- Sits between the test/control sequencer and the trigger-capture unit.

---
 rtl/trig_pkg.sv | 18 +
 rtl/trig_fifo.sv | 53 +++++
 rtl/trig_issuer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// rtl/trig_pkg.sv - shared state type, default width and saturating helper for the trig/din/crfm interface
package trig_pkg;

  localparam int TRIG_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    WAIT_ACK,
    GAP
  } trig_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/trig_fifo.sv
// rtl/trig_fifo.sv - synchronous byte queue feeding the trigger issuer; head is the oldest entry
module trig_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trig_issuer.sv
// rtl/trig_issuer.sv - queued trig/din issuer with bounded retry; TRIG_ISSUER_STATS_EN adds ok/drop/retry counters
module trig_issuer
  import trig_pkg::*;
#(
  parameter int DATA_W     = TRIG_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int MAX_RETRY  = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] din,
  output logic              trig,
  input  logic              crfm,
  output logic              done,
  output logic              err,
  output logic              busy
`ifdef TRIG_ISSUER_STATS_EN
  ,
  output logic [15:0]       ok_cnt,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       retry_cnt_total
`endif
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  trig_state_t       state;
  logic [WW-1:0]     wait_cnt;
  logic [RW-1:0]     retry_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              acked;
  logic              timed_out;
  logic              retry;
  logic              drop;

  assign s_ready   = !full;
  assign push      = s_valid && s_ready;
  assign acked     = (state == WAIT_ACK) && crfm;
  assign timed_out = (state == WAIT_ACK) && !crfm && (wait_cnt == WAIT_LAST);
  assign retry     = timed_out && (retry_cnt < RETRY_MAX);
  assign drop      = timed_out && !(retry_cnt < RETRY_MAX);
  // The head stays queued for the whole transfer so retries reuse it untouched.
  assign pop       = acked || drop;
  assign busy      = (state != IDLE) || !empty;

  trig_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      din       <= '0;
      trig      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wait_cnt  <= '0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      trig <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            din       <= head;
            retry_cnt <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          trig  <= 1'b1;
          state <= PULSE;
        end
        PULSE: begin
          wait_cnt <= '0;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (acked || drop) begin
            done    <= acked;
            err     <= drop;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (retry) begin
            retry_cnt <= retry_cnt + 1'b1;
            state     <= SETUP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRIG_ISSUER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt          <= '0;
      drop_cnt        <= '0;
      retry_cnt_total <= '0;
    end else begin
      if (done)  ok_cnt          <= sat_inc16(ok_cnt);
      if (err)   drop_cnt        <= sat_inc16(drop_cnt);
      if (retry) retry_cnt_total <= sat_inc16(retry_cnt_total);
    end
  end
`endif

endmodule
